// File: rtl/mem_access_stage_if.sv
// Signal bundle between the MEM stage and its neighbours: EX/MEM inputs, data-memory bus,
// MEM/WB outputs, upstream stall and error pulses.
interface mem_access_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_alu_result;
  logic [XLEN-1:0] ex_store_data;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;

  logic            stall_out;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_data;

  logic            misalign_err;
  logic            bus_err;

  // master: the MEM stage itself
  modport master (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_alu_result, ex_store_data,
           ex_rd, ex_reg_write, mem_ready, mem_rvalid, mem_rdata,
    output stall_out, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           wb_valid, wb_rd, wb_reg_write, wb_data, misalign_err, bus_err
  );

  // slave: pipeline neighbours and data memory
  modport slave (
    output ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_alu_result, ex_store_data,
           ex_rd, ex_reg_write, mem_ready, mem_rvalid, mem_rdata,
    input  stall_out, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           wb_valid, wb_rd, wb_reg_write, wb_data, misalign_err, bus_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM pipeline stage: turns loads/stores into req/ready/rvalid transfers on a
// variable-latency data memory, aligns load data, builds store strobes and stalls upstream.
module mem_access_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input logic                i_clk,
  input logic                i_rst,
  mem_access_stage_if.master bus
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [XLEN-1:0] r_addr, w_addr_n;
  logic [XLEN-1:0] r_wdata, w_wdata_n;
  logic [3:0]      r_wstrb, w_wstrb_n;
  logic            r_we, w_we_n;
  logic [2:0]      r_funct3, w_funct3_n;
  logic [4:0]      r_rd, w_rd_n;
  logic            r_reg_write, w_reg_write_n;

  logic            r_wb_valid, w_wb_valid_n;
  logic [4:0]      r_wb_rd, w_wb_rd_n;
  logic            r_wb_reg_write, w_wb_reg_write_n;
  logic [XLEN-1:0] r_wb_data, w_wb_data_n;
  logic            r_misalign, w_misalign_n;
  logic            r_bus_err, w_bus_err_n;

  logic            w_stall;
  logic            w_req;
  logic [1:0]      w_lane;
  logic            w_is_mem;
  logic            w_misalign;
  logic [XLEN-1:0] w_st_wdata;
  logic [3:0]      w_st_wstrb;
  logic [7:0]      w_ld_byte;
  logic [15:0]     w_ld_half;
  logic [XLEN-1:0] w_ld_data;

  assign w_lane   = bus.ex_alu_result[1:0];
  assign w_is_mem = bus.ex_mem_read | bus.ex_mem_write;
  // funct3[1:0]: 00 byte, 01 half, 1x word
  assign w_misalign = ((bus.ex_funct3[1:0] == 2'b01) && w_lane[0]) ||
                      (bus.ex_funct3[1] && (w_lane != 2'b00));

  // Store lane replication and byte enables
  always_comb begin
    w_st_wdata = bus.ex_store_data;
    w_st_wstrb = 4'b1111;
    case (bus.ex_funct3[1:0])
      2'b00: begin
        w_st_wdata = {(XLEN/8){bus.ex_store_data[7:0]}};
        w_st_wstrb = 4'b0001 << w_lane;
      end
      2'b01: begin
        w_st_wdata = {(XLEN/16){bus.ex_store_data[15:0]}};
        w_st_wstrb = w_lane[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    w_ld_byte = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_ld_half = bus.mem_rdata[{r_addr[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_ld_data = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_data = {{(XLEN-8){1'b0}}, w_ld_byte};
      3'b001:  w_ld_data = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_data = {{(XLEN-16){1'b0}}, w_ld_half};
      default: w_ld_data = bus.mem_rdata;
    endcase
  end

  // Next-state, transfer bookkeeping and write-back generation
  always_comb begin
    w_state_n        = r_state;
    w_cnt_n          = r_cnt;
    w_addr_n         = r_addr;
    w_wdata_n        = r_wdata;
    w_wstrb_n        = r_wstrb;
    w_we_n           = r_we;
    w_funct3_n       = r_funct3;
    w_rd_n           = r_rd;
    w_reg_write_n    = r_reg_write;
    w_wb_valid_n     = 1'b0;
    w_wb_rd_n        = r_wb_rd;
    w_wb_reg_write_n = 1'b0;
    w_wb_data_n      = r_wb_data;
    w_misalign_n     = 1'b0;
    w_bus_err_n      = 1'b0;
    w_stall          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.ex_valid) begin
          w_wb_rd_n = bus.ex_rd;
          if (!w_is_mem) begin
            w_wb_valid_n     = 1'b1;
            w_wb_reg_write_n = bus.ex_reg_write;
            w_wb_data_n      = bus.ex_alu_result;
          end else if (w_misalign) begin
            w_wb_valid_n = 1'b1;
            w_misalign_n = 1'b1;
            w_wb_data_n  = '0;
          end else begin
            w_we_n        = !bus.ex_mem_read;
            w_addr_n      = bus.ex_alu_result;
            w_wdata_n     = bus.ex_mem_read ? '0 : w_st_wdata;
            w_wstrb_n     = bus.ex_mem_read ? 4'b0000 : w_st_wstrb;
            w_funct3_n    = bus.ex_funct3;
            w_rd_n        = bus.ex_rd;
            w_reg_write_n = bus.ex_reg_write;
            w_cnt_n       = '0;
            w_state_n     = S_REQ;
            w_stall       = 1'b1;
          end
        end
      end

      S_REQ: begin
        if (bus.mem_ready && (r_we || bus.mem_rvalid)) begin
          w_wb_valid_n     = 1'b1;
          w_wb_rd_n        = r_rd;
          w_wb_reg_write_n = !r_we && r_reg_write;
          w_wb_data_n      = r_we ? '0 : w_ld_data;
          w_state_n        = S_IDLE;
        end else if (bus.mem_ready) begin
          w_cnt_n   = '0;
          w_state_n = S_RESP;
          w_stall   = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_wb_valid_n = 1'b1;
          w_wb_rd_n    = r_rd;
          w_wb_data_n  = '0;
          w_bus_err_n  = 1'b1;
          w_state_n    = S_IDLE;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
          w_stall = 1'b1;
        end
      end

      S_RESP: begin
        if (bus.mem_rvalid) begin
          w_wb_valid_n     = 1'b1;
          w_wb_rd_n        = r_rd;
          w_wb_reg_write_n = r_reg_write;
          w_wb_data_n      = w_ld_data;
          w_state_n        = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_wb_valid_n = 1'b1;
          w_wb_rd_n    = r_rd;
          w_wb_data_n  = '0;
          w_bus_err_n  = 1'b1;
          w_state_n    = S_IDLE;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
          w_stall = 1'b1;
        end
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_wstrb        <= '0;
      r_we           <= 1'b0;
      r_funct3       <= '0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
      r_wb_data      <= '0;
      r_misalign     <= 1'b0;
      r_bus_err      <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_cnt          <= w_cnt_n;
      r_addr         <= w_addr_n;
      r_wdata        <= w_wdata_n;
      r_wstrb        <= w_wstrb_n;
      r_we           <= w_we_n;
      r_funct3       <= w_funct3_n;
      r_rd           <= w_rd_n;
      r_reg_write    <= w_reg_write_n;
      r_wb_valid     <= w_wb_valid_n;
      r_wb_rd        <= w_wb_rd_n;
      r_wb_reg_write <= w_wb_reg_write_n;
      r_wb_data      <= w_wb_data_n;
      r_misalign     <= w_misalign_n;
      r_bus_err      <= w_bus_err_n;
    end
  end

  // stall is combinational; reset forces it low so every output reads 0 under reset
  assign bus.stall_out    = w_stall & !i_rst;

  assign w_req            = (r_state == S_REQ);
  assign bus.mem_req      = w_req;
  assign bus.mem_we       = w_req & r_we;
  assign bus.mem_addr     = w_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign bus.mem_wdata    = w_req ? r_wdata : '0;
  assign bus.mem_wstrb    = w_req ? r_wstrb : 4'b0000;

  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.wb_reg_write = r_wb_reg_write;
  assign bus.wb_data      = r_wb_data;
  assign bus.misalign_err = r_misalign;
  assign bus.bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed spec scenarios, reset abort, then randomized
// instructions checked against an arithmetic reference model and a behavioural memory.
module tb_mem_access_stage;
  localparam int unsigned XLEN = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_access_stage_if #(.XLEN(XLEN)) bus ();

  mem_access_stage #(.XLEN(XLEN), .TIMEOUT_CYC(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Expected load value from the access rules, using shifts and modulo arithmetic
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] v;
    int unsigned lane;
    lane = addr % 4;
    case (acc_size(f3))
      1: begin
        v = (rdata >> (8 * lane)) % 256;
        if (!f3[2] && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2: begin
        v = (rdata >> (16 * (lane / 2))) % 65536;
        if (!f3[2] && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
    case (acc_size(f3))
      1:       return 32'(1 << (addr % 4));
      2:       return 32'(3 << (addr % 4));
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (acc_size(f3))
      1:       return (d % 256) * 32'h0101_0101;
      2:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic drive_idle();
    bus.ex_valid      = 1'b0;
    bus.ex_mem_read   = 1'b0;
    bus.ex_mem_write  = 1'b0;
    bus.ex_funct3     = 3'b000;
    bus.ex_alu_result = '0;
    bus.ex_store_data = '0;
    bus.ex_rd         = '0;
    bus.ex_reg_write  = 1'b0;
    bus.mem_ready     = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  // One instruction through the stage; bench plays the memory with the given delays.
  // rdy_dly: REQ cycles before mem_ready; rv_dly: cycles from ready to rvalid (0 = same cycle).
  task automatic run_instr(input string nm, input logic rd_en, input logic wr_en,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input logic [4:0] rd, input logic rw,
                           input int rdy_dly, input int rv_dly);
    logic        is_mem, misal, exp_start, done, tmo, ready, rvalid, resp_ph, exp_rw;
    logic [31:0] exp_data;
    int          wcnt;
    is_mem    = rd_en | wr_en;
    misal     = is_mem && ((addr % acc_size(f3)) != 0);
    exp_start = is_mem && !misal;
    tmo       = 1'b0;
    resp_ph   = 1'b0;
    wcnt      = 0;
    done      = !exp_start;

    @(negedge clk);
    bus.ex_valid      = 1'b1;
    bus.ex_mem_read   = rd_en;
    bus.ex_mem_write  = wr_en;
    bus.ex_funct3     = f3;
    bus.ex_alu_result = addr;
    bus.ex_store_data = sdata;
    bus.ex_rd         = rd;
    bus.ex_reg_write  = rw;
    bus.mem_ready     = 1'b0;
    bus.mem_rvalid    = 1'b0;
    #1;
    chk({nm, ":wb_valid_before"}, bus.wb_valid, 1'b0);
    chk({nm, ":stall_issue"}, bus.stall_out, exp_start);
    chk({nm, ":req_issue"}, bus.mem_req, 1'b0);

    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      bus.ex_alu_result = $urandom;
      bus.ex_store_data = $urandom;
      bus.ex_rd         = 5'($urandom);
      if (!resp_ph) begin
        ready  = (wcnt == rdy_dly);
        rvalid = ready && !wr_en && (rv_dly == 0);
      end else begin
        ready  = 1'b0;
        rvalid = (wcnt == rv_dly - 1);
      end
      bus.mem_ready  = ready;
      bus.mem_rvalid = rvalid;
      bus.mem_rdata  = rvalid ? rdata : $urandom;
      #1;
      chk({nm, ":mem_req"}, bus.mem_req, !resp_ph);
      if (!resp_ph) begin
        chk({nm, ":mem_we"}, bus.mem_we, wr_en);
        chk({nm, ":mem_addr"}, bus.mem_addr, addr - (addr % 4));
        if (wr_en) begin
          chk({nm, ":mem_wstrb"}, 32'(bus.mem_wstrb), ref_strb(f3, addr));
          chk({nm, ":mem_wdata"}, bus.mem_wdata, ref_wdata(f3, sdata));
        end
        done = ready && (wr_en || rvalid);
        tmo  = !ready && (wcnt == 15);
      end else begin
        done = rvalid;
        tmo  = !rvalid && (wcnt == 15);
      end
      chk({nm, ":stall"}, bus.stall_out, !(done || tmo));
      if (!resp_ph && ready && !done) begin
        resp_ph = 1'b1;
        wcnt    = 0;
      end else begin
        wcnt++;
      end
      if (tmo) done = 1'b1;
    end
    chk({nm, ":finished_in_bound"}, done, 1'b1);

    exp_data = 32'd0;
    if (!is_mem) begin
      exp_rw   = rw;
      exp_data = addr;
    end else if (misal || tmo || wr_en) begin
      exp_rw = 1'b0;
    end else begin
      exp_rw   = rw;
      exp_data = ref_load(f3, addr, rdata);
    end

    @(negedge clk);
    drive_idle();
    #1;
    chk({nm, ":wb_valid"}, bus.wb_valid, 1'b1);
    chk({nm, ":wb_reg_write"}, bus.wb_reg_write, exp_rw);
    chk({nm, ":misalign_err"}, bus.misalign_err, misal);
    chk({nm, ":bus_err"}, bus.bus_err, tmo);
    chk({nm, ":stall_after"}, bus.stall_out, 1'b0);
    chk({nm, ":req_after"}, bus.mem_req, 1'b0);
    if (!is_mem || exp_rw) chk({nm, ":wb_data"}, bus.wb_data, exp_data);
    if (exp_rw) chk({nm, ":wb_rd"}, 32'(bus.wb_rd), 32'(rd));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ":stall"}, bus.stall_out, 1'b0);
    chk({nm, ":mem_req"}, bus.mem_req, 1'b0);
    chk({nm, ":mem_we"}, bus.mem_we, 1'b0);
    chk({nm, ":mem_addr"}, bus.mem_addr, 32'd0);
    chk({nm, ":mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({nm, ":mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
    chk({nm, ":wb_valid"}, bus.wb_valid, 1'b0);
    chk({nm, ":wb_rd"}, 32'(bus.wb_rd), 32'd0);
    chk({nm, ":wb_reg_write"}, bus.wb_reg_write, 1'b0);
    chk({nm, ":wb_data"}, bus.wb_data, 32'd0);
    chk({nm, ":misalign_err"}, bus.misalign_err, 1'b0);
    chk({nm, ":bus_err"}, bus.bus_err, 1'b0);
  endtask

  logic [2:0] ld_f3 [5];
  logic [2:0] st_f3 [3];

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind;
    total = 0;
    bad   = 0;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_f3 = '{3'b000, 3'b001, 3'b010};
    rst   = 1'b1;
    drive_idle();

    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed scenarios
    run_instr("addi",     1'b0, 1'b0, 3'b000, 32'h0000_0008, 32'h0, 32'h0, 5'd3, 1'b1, 0, 0);
    run_instr("lw_slow",  1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 5'd5, 1'b1, 0, 3);
    run_instr("lb_neg",   1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'h0, 32'h8000_0000, 5'd6, 1'b1, 0, 1);
    run_instr("lbu",      1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'h0, 32'h8000_0000, 5'd6, 1'b1, 0, 1);
    run_instr("sh_hi",    1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h1234_ABCD, 32'h0, 5'd7, 1'b1, 1, 0);
    run_instr("lw_misal", 1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 5'd8, 1'b1, 0, 0);
    run_instr("sh_misal", 1'b0, 1'b1, 3'b001, 32'h0000_0021, 32'h55, 32'h0, 5'd8, 1'b0, 0, 0);
    run_instr("lw_tmo",   1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 5'd9, 1'b1, 100, 0);
    run_instr("lw_rtmo",  1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h0, 5'd9, 1'b1, 0, 20);
    run_instr("sb_lane1", 1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'hFFFF_FF5A, 32'h0, 5'd1, 1'b1, 0, 0);
    run_instr("lh_lane2", 1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'h0, 32'h9ABC_1234, 5'd10, 1'b1, 2, 0);
    run_instr("lhu_same", 1'b1, 1'b0, 3'b101, 32'h0000_0022, 32'h0, 32'h9ABC_1234, 5'd11, 1'b1, 0, 0);
    run_instr("sw",       1'b0, 1'b1, 3'b010, 32'h0000_0030, 32'hCAFE_F00D, 32'h0, 5'd12, 1'b1, 0, 0);

    // Reset while waiting in RESP, then a stale rvalid
    @(negedge clk);
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_funct3 = 3'b010;
    bus.ex_alu_result = 32'h0000_0050; bus.ex_rd = 5'd4; bus.ex_reg_write = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_resp");
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    #1;
    chk("late_rvalid:stall", bus.stall_out, 1'b0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    #1;
    chk("late_rvalid:wb_valid", bus.wb_valid, 1'b0);
    chk("late_rvalid:mem_req", bus.mem_req, 1'b0);

    // Randomized instruction mix
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      a    = $urandom & 32'h0000_FFFF;
      if (kind == 0) begin
        run_instr("rnd_alu", 1'b0, 1'b0, 3'($urandom), $urandom, 32'h0, 32'h0,
                  5'($urandom), 1'($urandom), 0, 0);
      end else if (kind == 1) begin
        f3 = ld_f3[$urandom_range(0, 4)];
        run_instr("rnd_ld", 1'b1, 1'b0, f3, a, 32'h0, $urandom, 5'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else begin
        f3 = st_f3[$urandom_range(0, 2)];
        run_instr("rnd_st", 1'b0, 1'b1, f3, a, $urandom, 32'h0, 5'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 0);
      end
    end

    @(negedge clk);
    #1;
    chk("final:wb_valid_idle", bus.wb_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
